regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback stage that drives the write port of `register_file` (`reg_write`, `write_index`, `write_data`). It merges single-cycle ALU results with multi-cycle load returns and tracks in-flight load destinations in an in-order pending queue. It publishes a per-register busy scoreboard so decode can stall on RAW hazards. All write-port outputs are registered.

## Interface
- `DATA_W`, 32, register data width
- `IDX_W`, 5, register index width (2**IDX_W registers)
- `DEPTH`, 2, pending-load queue entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `nRST`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle; always accepted
- `alu_index`  in  IDX_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `mem_req_valid`  in  1  load issued; enqueue destination
- `mem_req_index`  in  IDX_W  load destination register
- `mem_rsp_valid`  in  1  load data available
- `mem_rsp_data`  in  DATA_W  load data
- `mem_rsp_ready`  out  1  load response accepted this cycle
- `reg_write`  out  1  register-file write enable
- `write_index`  out  IDX_W  register-file write index
- `write_data`  out  DATA_W  register-file write data
- `busy_mask`  out  2**IDX_W  bit i = register i has an unreturned load
- `pending_full`  out  1  queue holds DEPTH entries

## Operation
- Async reset (`nRST`=0): queue empty, `reg_write`=0, `write_index`=0, `write_data`=0, `busy_mask`=0, `pending_full`=0, `mem_rsp_ready`=0. Any queued loads are discarded.
- **Pending queue:** circular FIFO of indices with head/tail pointers and a count (0..DEPTH).
  - `mem_req_valid` with count<DEPTH pushes `mem_req_index`.
  - `mem_req_valid` while `pending_full`=1 is ignored with no state change, even if a pop occurs in the same cycle. Upstream must not issue it.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- **Arbitration** (combinational): `mem_rsp_ready` = (count>0) && !`alu_valid`. The ALU always wins. A load response waits under valid/ready, holding its data stable until accepted.
- **Write selection** (registered at the next rising edge):
  - ALU: if `alu_valid`, then `reg_write` ← (`alu_index`≠0), `write_index` ← `alu_index`, `write_data` ← `alu_data`.
  - Load: if `mem_rsp_valid` && `mem_rsp_ready`, then `reg_write` ← (head≠0), `write_index` ← head index, `write_data` ← `mem_rsp_data`, and the head is popped.
  - Otherwise `reg_write` ← 0. `write_index` and `write_data` hold their values.
- **x0:** a write to index 0 never asserts `reg_write`. The load-queue pop still occurs.
- **busy_mask:** OR over valid queue entries of one-hot(index), excluding index 0. It is derived from registered state. A bit clears on the same edge the load's `reg_write` is asserted. Duplicate indices stay busy until the last matching entry pops.
- **WAW rule:** `alu_valid` to a register whose `busy_mask` bit is set is an upstream violation. Writes still occur strictly in acceptance order. No forwarding is provided.

## Timing
- ALU latency: result on cycle N → `reg_write` high in cycle N+1 → register file updated at the edge ending N+1.
- Load latency: response handshake in cycle N → `reg_write` high in N+1; `busy_mask` bit cleared from N+1.
- Push in cycle N → `busy_mask` bit and `pending_full` reflect it from N+1.
- Throughput: one register-file write per cycle. A continuous `alu_valid` stream starves loads indefinitely; this is the accepted design trade-off.
- Reset asserted mid-operation clears outputs immediately (asynchronously). The first possible `reg_write` is the cycle after the first edge following deassertion.

## Test plan
- Reset: hold `nRST`=0 for 2 cycles with `alu_valid`=1 → `reg_write`=0, `busy_mask`=0, `write_index`=0, `write_data`=0 throughout.
- ALU write: `alu_index`=1, `alu_data`=0xAAAAAAAA for 1 cycle → next cycle `reg_write`=1, `write_index`=1, `write_data`=0xAAAAAAAA; following cycle `reg_write`=0. The same stimulus with `alu_index`=0 gives `reg_write`=0.
- Load order: push indices 2 then 4 → `busy_mask`=0x14, `pending_full`=1. A third push to 8 is ignored. Responses 0xFACEAAAA then 0xAAAAFACE produce writes to 2 then 4 in order; `busy_mask` goes 0x10, then 0x0.
- Conflict: `mem_rsp_valid`=1 and `alu_valid`=1 (index 3, 0x11) in the same cycle → `mem_rsp_ready`=0, ALU write issued first. The load write follows one cycle later with its held data.
- Simultaneous push/pop at count=1: push index 5 while popping index 2 → count stays 1, `busy_mask`=0x20, `write_index`=2.
- Reset mid-flight: assert `nRST` with 2 loads pending → `busy_mask`=0 and `pending_full`=0 immediately. A later response with `mem_rsp_valid`=1 sees `mem_rsp_ready`=0.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback stage's datapath signals: ALU result input,
// load request/response channels and the register-file write port.
//
// Handshake semantics: the ALU channel has no ready; a cycle with
// alu_valid=1 is always consumed. The load response channel is a strict
// valid/ready pair: a transfer happens on a rising edge where both
// mem_rsp_valid and mem_rsp_ready are high; while valid is high and ready
// is low the source holds mem_rsp_data stable. mem_req_valid is a
// one-cycle push with no ready; the source must observe pending_full.
interface regfile_writeback_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
);
   logic                  alu_valid;
   logic [IDX_W-1:0]      alu_index;
   logic [DATA_W-1:0]     alu_data;
   logic                  mem_req_valid;
   logic [IDX_W-1:0]      mem_req_index;
   logic                  mem_rsp_valid;
   logic [DATA_W-1:0]     mem_rsp_data;
   logic                  mem_rsp_ready;
   logic                  reg_write;
   logic [IDX_W-1:0]      write_index;
   logic [DATA_W-1:0]     write_data;
   logic [2**IDX_W-1:0]   busy_mask;
   logic                  pending_full;

   // Upstream pipeline / memory side: drives results and requests.
   modport master (
      output alu_valid, alu_index, alu_data,
      output mem_req_valid, mem_req_index,
      output mem_rsp_valid, mem_rsp_data,
      input  mem_rsp_ready,
      input  reg_write, write_index, write_data,
      input  busy_mask, pending_full
   );

   // Writeback stage side.
   modport slave (
      input  alu_valid, alu_index, alu_data,
      input  mem_req_valid, mem_req_index,
      input  mem_rsp_valid, mem_rsp_data,
      output mem_rsp_ready,
      output reg_write, write_index, write_data,
      output busy_mask, pending_full
   );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback stage: merges single-cycle ALU results with in-order load
// returns onto one registered register-file write port, and publishes a
// busy scoreboard of registers waiting on an outstanding load.
module regfile_writeback #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5,
   parameter int DEPTH  = 2
) (
   input  logic                 clk,
   input  logic                 nRST,
   regfile_writeback_if.slave   bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int NREG = 2 ** IDX_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Pending-load queue state (destination indices only; data comes with the response)
   logic [IDX_W-1:0]  queue_q [DEPTH];
   logic [IDX_W-1:0]  queue_d [DEPTH];
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   // Registered write port
   logic              reg_write_q, reg_write_d;
   logic [IDX_W-1:0]  write_index_q, write_index_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   logic              full;
   logic              push_en;
   logic              pop_en;
   logic              rsp_ready;
   logic [IDX_W-1:0]  head_index;
   logic [NREG-1:0]   busy_c;
   logic [PW-1:0]     slot_off;

   assign full       = (count_q == FULL_CNT);
   // ALU always wins the write port; a load only goes when no ALU result is present
   assign rsp_ready  = (count_q != '0) && !bus.alu_valid;
   // A push into a full queue is dropped even if a pop frees a slot this cycle
   assign push_en    = bus.mem_req_valid && !full;
   assign pop_en     = bus.mem_rsp_valid && rsp_ready;
   assign head_index = queue_q[head_q];

   // Next-state for queue pointers/count and write-port selection
   always_comb begin
      queue_d       = queue_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      reg_write_d   = 1'b0;
      write_index_d = write_index_q;
      write_data_d  = write_data_q;

      if (push_en) begin
         queue_d[tail_q] = bus.mem_req_index;
         tail_d          = tail_q + 1'b1;
      end
      if (pop_en) begin
         head_d = head_q + 1'b1;
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // x0 is hardwired: index/data still update but the enable stays low
      if (bus.alu_valid) begin
         reg_write_d   = (bus.alu_index != '0);
         write_index_d = bus.alu_index;
         write_data_d  = bus.alu_data;
      end else if (pop_en) begin
         reg_write_d   = (head_index != '0);
         write_index_d = head_index;
         write_data_d  = bus.mem_rsp_data;
      end
   end

   // State registers, cleared asynchronously (queued loads are discarded)
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            queue_q[i] <= '0;
         end
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         reg_write_q   <= 1'b0;
         write_index_q <= '0;
         write_data_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            queue_q[i] <= queue_d[i];
         end
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         reg_write_q   <= reg_write_d;
         write_index_q <= write_index_d;
         write_data_q  <= write_data_d;
      end
   end

   // Busy scoreboard: OR of one-hot destinations over occupied slots, x0 excluded
   always_comb begin
      busy_c   = '0;
      slot_off = '0;
      for (int s = 0; s < DEPTH; s++) begin
         slot_off = PW'(s) - head_q;
         if ((CW'(slot_off) < count_q) && (queue_q[s] != '0)) begin
            busy_c[queue_q[s]] = 1'b1;
         end
      end
   end

   assign bus.mem_rsp_ready = rsp_ready;
   assign bus.reg_write     = reg_write_q;
   assign bus.write_index   = write_index_q;
   assign bus.write_data    = write_data_q;
   assign bus.busy_mask     = busy_c;
   assign bus.pending_full  = full;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU writes, in-order load
// returns, ALU/load conflict, push/pop overlap, x0 and duplicate loads,
// and reset while loads are pending.
module tb_regfile_writeback;

   logic clk;
   logic nRST;
   int   n_tests;
   int   n_fail;

   regfile_writeback_if #(.DATA_W(32), .IDX_W(5)) bus ();

   regfile_writeback #(.DATA_W(32), .IDX_W(5), .DEPTH(2)) dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid     = 1'b0;
      bus.alu_index     = '0;
      bus.alu_data      = '0;
      bus.mem_req_valid = 1'b0;
      bus.mem_req_index = '0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      bus.alu_valid = 1'b1;
      bus.alu_index = 5'd5;
      bus.alu_data  = 32'h5555_5555;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0b exp=0", bus.reg_write); end
         n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL rst_busy got=%h exp=0", bus.busy_mask); end
         n_tests++; if (bus.write_index !== 5'd0) begin n_fail++; $display("FAIL rst_idx got=%0d exp=0", bus.write_index); end
         n_tests++; if (bus.write_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", bus.write_data); end
         n_tests++; if (bus.pending_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%0b exp=0", bus.pending_full); end
         n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0b exp=0", bus.mem_rsp_ready); end
      end
      idle_inputs();
      nRST = 1'b1;
      tick();
      n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_post_we got=%0b exp=0", bus.reg_write); end
   endtask

   task automatic test_alu_write();
      bus.alu_valid = 1'b1; bus.alu_index = 5'd1; bus.alu_data = 32'hAAAA_AAAA;
      tick();
      bus.alu_valid = 1'b0;
      n_tests++; if (bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%0b exp=1", bus.reg_write); end
      n_tests++; if (bus.write_index !== 5'd1) begin n_fail++; $display("FAIL alu_idx got=%0d exp=1", bus.write_index); end
      n_tests++; if (bus.write_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL alu_data got=%h exp=aaaaaaaa", bus.write_data); end
      tick();
      n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop got=%0b exp=0", bus.reg_write); end
      n_tests++; if (bus.write_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL alu_data_hold got=%h exp=aaaaaaaa", bus.write_data); end
      // x0 destination: port updates but the enable stays low
      bus.alu_valid = 1'b1; bus.alu_index = 5'd0; bus.alu_data = 32'h1234_5678;
      tick();
      bus.alu_valid = 1'b0;
      n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL alu_x0_we got=%0b exp=0", bus.reg_write); end
      n_tests++; if (bus.write_index !== 5'd0) begin n_fail++; $display("FAIL alu_x0_idx got=%0d exp=0", bus.write_index); end
      n_tests++; if (bus.write_data !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_x0_data got=%h exp=12345678", bus.write_data); end
   endtask

   task automatic test_load_order();
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd2;
      tick();
      n_tests++; if (bus.busy_mask !== 32'h4) begin n_fail++; $display("FAIL ld_busy1 got=%h exp=4", bus.busy_mask); end
      n_tests++; if (bus.pending_full !== 1'b0) begin n_fail++; $display("FAIL ld_full1 got=%0b exp=0", bus.pending_full); end
      bus.mem_req_index = 5'd4;
      tick();
      n_tests++; if (bus.busy_mask !== 32'h14) begin n_fail++; $display("FAIL ld_busy2 got=%h exp=14", bus.busy_mask); end
      n_tests++; if (bus.pending_full !== 1'b1) begin n_fail++; $display("FAIL ld_full2 got=%0b exp=1", bus.pending_full); end
      bus.mem_req_index = 5'd8;
      tick();
      bus.mem_req_valid = 1'b0;
      n_tests++; if (bus.busy_mask !== 32'h14) begin n_fail++; $display("FAIL ld_ignored got=%h exp=14", bus.busy_mask); end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hFACE_AAAA;
      #1;
      n_tests++; if (bus.mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready got=%0b exp=1", bus.mem_rsp_ready); end
      tick();
      n_tests++; if (bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL ld1_we got=%0b exp=1", bus.reg_write); end
      n_tests++; if (bus.write_index !== 5'd2) begin n_fail++; $display("FAIL ld1_idx got=%0d exp=2", bus.write_index); end
      n_tests++; if (bus.write_data !== 32'hFACE_AAAA) begin n_fail++; $display("FAIL ld1_data got=%h exp=faceaaaa", bus.write_data); end
      n_tests++; if (bus.busy_mask !== 32'h10) begin n_fail++; $display("FAIL ld1_busy got=%h exp=10", bus.busy_mask); end
      n_tests++; if (bus.pending_full !== 1'b0) begin n_fail++; $display("FAIL ld1_full got=%0b exp=0", bus.pending_full); end
      bus.mem_rsp_data = 32'hAAAA_FACE;
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.write_index !== 5'd4) begin n_fail++; $display("FAIL ld2_idx got=%0d exp=4", bus.write_index); end
      n_tests++; if (bus.write_data !== 32'hAAAA_FACE) begin n_fail++; $display("FAIL ld2_data got=%h exp=aaaaface", bus.write_data); end
      n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL ld2_busy got=%h exp=0", bus.busy_mask); end
      n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL ld_empty_ready got=%0b exp=0", bus.mem_rsp_ready); end
      tick();
      n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL ld_idle_we got=%0b exp=0", bus.reg_write); end
   endtask

   task automatic test_full_push_pop();
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd1;
      tick();
      bus.mem_req_index = 5'd3;
      tick();
      n_tests++; if (bus.busy_mask !== 32'hA) begin n_fail++; $display("FAIL fp_busy got=%h exp=a", bus.busy_mask); end
      // Push while full with a simultaneous pop: push must be dropped
      bus.mem_req_index = 5'd8; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0101;
      tick();
      bus.mem_req_valid = 1'b0;
      n_tests++; if (bus.write_index !== 5'd1) begin n_fail++; $display("FAIL fp_idx got=%0d exp=1", bus.write_index); end
      n_tests++; if (bus.busy_mask !== 32'h8) begin n_fail++; $display("FAIL fp_busy_after got=%h exp=8", bus.busy_mask); end
      bus.mem_rsp_data = 32'h0000_0303;
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.write_index !== 5'd3) begin n_fail++; $display("FAIL fp_idx2 got=%0d exp=3", bus.write_index); end
      n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL fp_drained got=%0b exp=0", bus.mem_rsp_ready); end
      tick();
   endtask

   task automatic test_conflict();
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd6;
      tick();
      bus.mem_req_valid = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_0006;
      bus.alu_valid = 1'b1; bus.alu_index = 5'd3; bus.alu_data = 32'h11;
      #1;
      n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL cf_ready got=%0b exp=0", bus.mem_rsp_ready); end
      tick();
      bus.alu_valid = 1'b0;
      n_tests++; if (bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL cf_alu_we got=%0b exp=1", bus.reg_write); end
      n_tests++; if (bus.write_index !== 5'd3) begin n_fail++; $display("FAIL cf_alu_idx got=%0d exp=3", bus.write_index); end
      n_tests++; if (bus.write_data !== 32'h11) begin n_fail++; $display("FAIL cf_alu_data got=%h exp=11", bus.write_data); end
      n_tests++; if (bus.busy_mask !== 32'h40) begin n_fail++; $display("FAIL cf_busy got=%h exp=40", bus.busy_mask); end
      #1;
      n_tests++; if (bus.mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL cf_ready2 got=%0b exp=1", bus.mem_rsp_ready); end
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.write_index !== 5'd6) begin n_fail++; $display("FAIL cf_ld_idx got=%0d exp=6", bus.write_index); end
      n_tests++; if (bus.write_data !== 32'hDEAD_0006) begin n_fail++; $display("FAIL cf_ld_data got=%h exp=dead0006", bus.write_data); end
      n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL cf_busy2 got=%h exp=0", bus.busy_mask); end
      tick();
   endtask

   task automatic test_push_pop();
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd2;
      tick();
      bus.mem_req_index = 5'd5; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h22;
      tick();
      bus.mem_req_valid = 1'b0;
      n_tests++; if (bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL pp_we got=%0b exp=1", bus.reg_write); end
      n_tests++; if (bus.write_index !== 5'd2) begin n_fail++; $display("FAIL pp_idx got=%0d exp=2", bus.write_index); end
      n_tests++; if (bus.busy_mask !== 32'h20) begin n_fail++; $display("FAIL pp_busy got=%h exp=20", bus.busy_mask); end
      n_tests++; if (bus.pending_full !== 1'b0) begin n_fail++; $display("FAIL pp_full got=%0b exp=0", bus.pending_full); end
      bus.mem_rsp_data = 32'h55;
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.write_index !== 5'd5) begin n_fail++; $display("FAIL pp_idx2 got=%0d exp=5", bus.write_index); end
      n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL pp_busy2 got=%h exp=0", bus.busy_mask); end
      tick();
   endtask

   task automatic test_x0_and_dup();
      // Load to x0: never busy, pops without a write enable
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd0;
      tick();
      bus.mem_req_valid = 1'b0;
      n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL x0_busy got=%h exp=0", bus.busy_mask); end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hCAFE_0000;
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_ld_we got=%0b exp=0", bus.reg_write); end
      n_tests++; if (bus.write_data !== 32'hCAFE_0000) begin n_fail++; $display("FAIL x0_ld_data got=%h exp=cafe0000", bus.write_data); end
      n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL x0_popped got=%0b exp=0", bus.mem_rsp_ready); end
      // Duplicate destination stays busy until the last entry pops
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd7;
      tick();
      tick();
      bus.mem_req_valid = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h7001;
      tick();
      n_tests++; if (bus.busy_mask !== 32'h80) begin n_fail++; $display("FAIL dup_busy got=%h exp=80", bus.busy_mask); end
      bus.mem_rsp_data = 32'h7002;
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL dup_busy2 got=%h exp=0", bus.busy_mask); end
      n_tests++; if (bus.write_data !== 32'h7002) begin n_fail++; $display("FAIL dup_data got=%h exp=7002", bus.write_data); end
      tick();
   endtask

   task automatic test_reset_midflight();
      bus.mem_req_valid = 1'b1; bus.mem_req_index = 5'd2;
      tick();
      bus.mem_req_index = 5'd4;
      tick();
      bus.mem_req_valid = 1'b0;
      n_tests++; if (bus.busy_mask !== 32'h14) begin n_fail++; $display("FAIL rm_pre_busy got=%h exp=14", bus.busy_mask); end
      nRST = 1'b0;
      #1;
      n_tests++; if (bus.busy_mask !== 32'h0) begin n_fail++; $display("FAIL rm_busy got=%h exp=0", bus.busy_mask); end
      n_tests++; if (bus.pending_full !== 1'b0) begin n_fail++; $display("FAIL rm_full got=%0b exp=0", bus.pending_full); end
      tick();
      nRST = 1'b1;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD0_0000;
      #1;
      n_tests++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready got=%0b exp=0", bus.mem_rsp_ready); end
      tick();
      bus.mem_rsp_valid = 1'b0;
      n_tests++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL rm_we got=%0b exp=0", bus.reg_write); end
      n_tests++; if (bus.write_data !== 32'h0) begin n_fail++; $display("FAIL rm_data got=%h exp=0", bus.write_data); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      nRST    = 1'b0;
      idle_inputs();
      test_reset();
      test_alu_write();
      test_load_order();
      test_full_push_pop();
      test_conflict();
      test_push_pop();
      test_x0_and_dup();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
